data_pack: RTL and testbench

- Serial-to-parallel packer: the inverse of the coefficient slicer.
- Accepts one W-bit coefficient per cycle over a valid/ready handshake.
- Assembles LANES coefficients into one LANES*W-bit word and presents it on a registered valid/ready output.
- Sits on the NTT result path: butterfly outputs are gathered back into 64-bit memory/bus words.

---
 rtl/ntt_pkg.sv | 13 +
 rtl/pack_out_reg.sv | 33 +++
 rtl/data_pack.sv | 72 +++++++
 tb/tb_data_pack.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Constants shared by the NTT coefficient slicer and packer so both agree on lane order.
// Lane 0 is the most significant W-bit field of a packed word.
package ntt_pkg;
   localparam int COEF_W     = 8;
   localparam int PACK_LANES = 8;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction
endpackage

// File: rtl/pack_out_reg.sv
// Single-entry output holding register, valid/ready. Load appears one cycle later.
// Backpressure: contents hold while out_valid && !out_ready; load and pop may share an edge.
module pack_out_reg #(
   parameter int DW = 64,
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [DW-1:0] load_data,
   input  logic [CW-1:0] load_count,
   input  logic          out_ready,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic [CW-1:0] out_count
);

   // The producer only asserts load when this register is empty or draining.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_count <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= load_data;
         out_count <= load_count;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/data_pack.sv
// Serial-to-parallel packer: LANES W-bit coefficients into one word, first coefficient in the MSB lane; word valid the cycle after completion.
// Backpressure: non-completing coefficients always accepted; a completing one waits while the output is stalled.
module data_pack
   import ntt_pkg::*;
#(
   parameter int LANES = PACK_LANES,
   parameter int W     = COEF_W
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [W-1:0]                in_data,
   input  logic                        in_last,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [LANES*W-1:0]          out_data,
   output logic [clog2(LANES+1)-1:0]   out_count
);

   localparam int CW = clog2(LANES + 1);
   localparam int IW = clog2(LANES);

   logic [IW-1:0]      lane_cnt;
   logic [LANES*W-1:0] asm_word;
   logic [LANES*W-1:0] merged;
   logic               completing;
   logic               accept;
   logic               word_done;

   assign completing = (lane_cnt == IW'(LANES - 1)) || in_last;
   assign in_ready   = !(out_valid && !out_ready) || !completing;
   assign accept     = in_valid && in_ready;
   assign word_done  = accept && completing;

   // Lanes beyond lane_cnt are still zero, so the completed word needs no masking.
   always_comb begin
      merged = asm_word;
      for (int l = 0; l < LANES; l++) begin
         if (lane_cnt == IW'(l)) merged[LANES*W-1-l*W -: W] = in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_cnt <= '0;
         asm_word <= '0;
      end else if (word_done) begin
         lane_cnt <= '0;
         asm_word <= '0;
      end else if (accept) begin
         lane_cnt <= lane_cnt + IW'(1);
         asm_word <= merged;
      end
   end

   pack_out_reg #(
      .DW (LANES * W),
      .CW (CW)
   ) u_out_reg (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (word_done),
      .load_data  (merged),
      .load_count (CW'(lane_cnt) + CW'(1)),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_count  (out_count)
   );

endmodule

// File: tb/tb_data_pack.sv
// Bench for data_pack: table vectors, directed corner sequences and randomized traffic
// checked against a queue-based reference model of the packing rules.
module tb_data_pack;
   localparam int LANES = 8;
   localparam int W     = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_data = 8'h00;
   logic        in_last = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_data;
   logic [3:0]  out_count;

   data_pack #(.LANES(LANES), .W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_count (out_count)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: coefficients of the word in progress plus the expected output register.
   logic [7:0]  part[$];
   logic        m_vld;
   logic [63:0] m_dat;
   logic [3:0]  m_cnt;

   // Values sampled by the last step.
   logic        s_rdy;
   logic        s_vld;
   logic [63:0] s_dat;
   logic [3:0]  s_cnt;

   typedef struct {
      logic        v;
      logic [7:0]  d;
      logic        last;
      logic        ordy;
      logic        e_rdy;
      logic        e_vld;
      logic [63:0] e_dat;
      logic [3:0]  e_cnt;
   } vec_t;

   vec_t tbl[14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] pack_ref();
      logic [63:0] w;
      w = 64'h0;
      for (int k = 0; k < part.size(); k++)
         w = w | (64'(part[k]) << ((LANES - 1 - k) * W));
      return w;
   endfunction

   // One clock cycle: entered and left at posedge+1.
   task automatic step(input logic v, input logic [7:0] d, input logic last, input logic ordy);
      logic comp, exp_rdy, acc;
      in_valid  = v;
      in_data   = d;
      in_last   = last;
      out_ready = ordy;
      #1;
      comp    = (part.size() == LANES - 1) || last;
      exp_rdy = !(m_vld && !ordy) || !comp;
      acc     = v && exp_rdy;
      s_rdy   = in_ready;
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      @(posedge clk);
      #1;
      if (acc) part.push_back(d);
      if (acc && comp) begin
         m_vld = 1'b1;
         m_dat = pack_ref();
         m_cnt = 4'(part.size());
         part.delete();
      end else if (m_vld && ordy) begin
         m_vld = 1'b0;
      end
      s_vld = out_valid;
      s_dat = out_data;
      s_cnt = out_count;
      chk("out_valid", 64'(out_valid), 64'(m_vld));
      if (m_vld) begin
         chk("out_data", out_data, m_dat);
         chk("out_count", 64'(out_count), 64'(m_cnt));
      end
   endtask

   task automatic async_reset();
      in_valid = 1'b0;
      in_last  = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'h0);
      chk("rst_out_data", out_data, 64'h0);
      chk("rst_out_count", 64'(out_count), 64'h0);
      chk("rst_in_ready", 64'(in_ready), 64'h1);
      part.delete();
      m_vld = 1'b0;
      m_dat = 64'h0;
      m_cnt = 4'h0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic v, input logic [7:0] d, input logic last,
                               input logic e_vld, input logic [63:0] e_dat, input logic [3:0] e_cnt);
      vec_t r;
      r.v = v; r.d = d; r.last = last; r.ordy = 1'b1; r.e_rdy = 1'b1;
      r.e_vld = e_vld; r.e_dat = e_dat; r.e_cnt = e_cnt;
      return r;
   endfunction

   initial begin
      for (int i = 0; i < 8; i++)
         tbl[i] = mk(1'b1, 8'(i + 1), 1'b0, (i == 7), 64'h0102030405060708, 4'd8);
      tbl[8]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 64'h0, 4'd0);
      tbl[9]  = mk(1'b1, 8'h0A, 1'b0, 1'b0, 64'h0, 4'd0);
      tbl[10] = mk(1'b1, 8'h0B, 1'b0, 1'b0, 64'h0, 4'd0);
      tbl[11] = mk(1'b1, 8'h0C, 1'b1, 1'b1, 64'h0A0B0C0000000000, 4'd3);
      tbl[12] = mk(1'b1, 8'h55, 1'b1, 1'b1, 64'h5500000000000000, 4'd1);
      tbl[13] = mk(1'b0, 8'h00, 1'b0, 1'b0, 64'h0, 4'd0);

      part.delete();
      m_vld = 1'b0;
      m_dat = 64'h0;
      m_cnt = 4'h0;

      // Power-on reset
      #2;
      chk("por_out_valid", 64'(out_valid), 64'h0);
      chk("por_out_data", out_data, 64'h0);
      chk("por_out_count", 64'(out_count), 64'h0);
      chk("por_in_ready", 64'(in_ready), 64'h1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Full word, partial flush, single-lane word back-to-back with a pop
      for (int i = 0; i < 14; i++) begin
         step(tbl[i].v, tbl[i].d, tbl[i].last, tbl[i].ordy);
         chk("tbl_in_ready", 64'(s_rdy), 64'(tbl[i].e_rdy));
         chk("tbl_out_valid", 64'(s_vld), 64'(tbl[i].e_vld));
         if (tbl[i].e_vld) begin
            chk("tbl_out_data", s_dat, tbl[i].e_dat);
            chk("tbl_out_count", 64'(s_cnt), 64'(tbl[i].e_cnt));
         end
      end

      // Back-to-back words, no input stall, pulses 8 cycles apart
      for (int i = 0; i < 16; i++) begin
         step(1'b1, (i < 8) ? 8'(i + 1) : 8'(16 - i), 1'b0, 1'b1);
         chk("b2b_in_ready", 64'(s_rdy), 64'h1);
         if (i == 7) begin
            chk("b2b_vld0", 64'(s_vld), 64'h1);
            chk("b2b_word0", s_dat, 64'h0102030405060708);
         end else if (i == 15) begin
            chk("b2b_vld1", 64'(s_vld), 64'h1);
            chk("b2b_word1", s_dat, 64'h0807060504030201);
         end else if (i >= 8) begin
            chk("b2b_gap", 64'(s_vld), 64'h0);
         end
      end
      step(1'b0, 8'h00, 1'b0, 1'b1);

      // Backpressure: one word held, seven more accepted, eighth waits for release
      for (int i = 0; i < 8; i++) step(1'b1, 8'(i + 1), 1'b0, 1'b0);
      chk("bp_held_vld", 64'(s_vld), 64'h1);
      for (int i = 0; i < 7; i++) begin
         step(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
         chk("bp_accept7", 64'(s_rdy), 64'h1);
         chk("bp_hold_data", s_dat, 64'h0102030405060708);
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 8'h18, 1'b0, 1'b0);
         chk("bp_stall_rdy", 64'(s_rdy), 64'h0);
         chk("bp_stall_data", s_dat, 64'h0102030405060708);
         chk("bp_stall_cnt", 64'(s_cnt), 64'd8);
      end
      step(1'b1, 8'h18, 1'b0, 1'b1);
      chk("bp_release_rdy", 64'(s_rdy), 64'h1);
      chk("bp_release_vld", 64'(s_vld), 64'h1);
      chk("bp_release_data", s_dat, 64'h1112131415161718);
      step(1'b0, 8'h00, 1'b0, 1'b1);

      // Reset mid-word discards the partial word
      for (int i = 0; i < 3; i++) step(1'b1, 8'hE0 + 8'(i), 1'b0, 1'b1);
      async_reset();
      for (int i = 0; i < 8; i++) step(1'b1, 8'(i + 1), 1'b0, 1'b1);
      chk("rst_resume_data", s_dat, 64'h0102030405060708);
      chk("rst_resume_cnt", 64'(s_cnt), 64'd8);
      step(1'b0, 8'h00, 1'b0, 1'b1);

      // Randomized traffic against the reference model
      for (int n = 0; n < 3000; n++) begin
         step(($urandom_range(9, 0) < 7), 8'($urandom), ($urandom_range(7, 0) == 0),
              ($urandom_range(9, 0) < 6));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
